button_press_encoder: RTL and testbench



---
 rtl/button_press_encoder.sv | 86 ++++++++
 tb/tb_button_press_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/button_press_encoder.sv
// Player-input front end: two-flop synchroniser, per-button debounce, and a
// press-edge priority encoder that emits one strobe per debounced press.
module button_press_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int NUM_BUTTONS     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  input  logic                   enable,
  output logic                   btn_valid,
  output logic [2:0]             btn_code,
  output logic                   btn_multi,
  output logic [NUM_BUTTONS-1:0] btn_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] s1_q, s2_q;
  logic [NUM_BUTTONS-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] press;
  logic                   valid_q, valid_d;
  logic [2:0]             code_q, code_d;
  logic                   multi_q, multi_d;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Only rising debounced levels count as presses; releases are ignored.
  assign press = stable_d & ~stable_q;

  always_comb begin
    valid_d = 1'b0;
    multi_d = 1'b0;
    code_d  = code_q;
    if (enable && (press != '0)) begin
      valid_d = 1'b1;
      multi_d = ((press & (press - 1'b1)) != '0);
      // Scan downward so the lowest set index is the one left in code_d.
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
        if (press[i]) code_d = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
      valid_q  <= 1'b0;
      code_q   <= 3'd0;
      multi_q  <= 1'b0;
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
      valid_q  <= valid_d;
      code_q   <= code_d;
      multi_q  <= multi_d;
    end
  end

  assign btn_valid = valid_q;
  assign btn_code  = code_q;
  assign btn_multi = multi_q;
  assign btn_held  = stable_q;

endmodule

// File: tb/tb_button_press_encoder.sv
// Directed bench for button_press_encoder: one instance with a 4-sample
// debounce and one with a 1-sample debounce, sharing a clock.
module tb_button_press_encoder;

  logic       clk = 1'b0;
  logic       rst_a, en_a, rst_b, en_b;
  logic [7:0] raw_a, raw_b;
  logic       val_a, mul_a, val_b, mul_b;
  logic [2:0] code_a, code_b;
  logic [7:0] held_a, held_b;

  int vecs = 0;
  int errs = 0;
  int strobes;
  logic [2:0] lcode;
  logic       lmulti;

  always #5 clk = ~clk;

  button_press_encoder #(.DEBOUNCE_CYCLES(4), .NUM_BUTTONS(8)) dut_a (
    .clk(clk), .reset(rst_a), .btn_raw(raw_a), .enable(en_a),
    .btn_valid(val_a), .btn_code(code_a), .btn_multi(mul_a), .btn_held(held_a)
  );

  button_press_encoder #(.DEBOUNCE_CYCLES(1), .NUM_BUTTONS(8)) dut_b (
    .clk(clk), .reset(rst_b), .btn_raw(raw_b), .enable(en_b),
    .btn_valid(val_b), .btn_code(code_b), .btn_multi(mul_b), .btn_held(held_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles on instance A, counting strobes and keeping the last code.
  task automatic run_a(input int n, output int cnt, output logic [2:0] c, output logic m);
    cnt = 0;
    c   = 3'd0;
    m   = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (val_a === 1'b1) begin
        cnt++;
        c = code_a;
        m = mul_a;
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1; raw_a = 8'h04;
    rst_b = 1'b1; en_b = 1'b1; raw_b = 8'h00;
    tick();
    tick();
    chk("rst_valid", {31'd0, val_a}, 32'd0);
    chk("rst_code",  {29'd0, code_a}, 32'd0);
    chk("rst_multi", {31'd0, mul_a}, 32'd0);
    chk("rst_held",  {24'd0, held_a}, 32'd0);

    // 1: held button 2, strobe after the 6th edge following reset release
    rst_a = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("t1_pre_valid", {31'd0, val_a}, 32'd0);
    end
    chk("t1_pre_held", {24'd0, held_a}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, val_a}, 32'd1);
    chk("t1_code",  {29'd0, code_a}, 32'd2);
    chk("t1_multi", {31'd0, mul_a}, 32'd0);
    chk("t1_held",  {24'd0, held_a}, 32'h04);
    run_a(8, strobes, lcode, lmulti);
    chk("t1_no_retrigger", strobes, 32'd0);
    chk("t1_held_hold", {24'd0, held_a}, 32'h04);

    // 2: release, then a 3-cycle glitch on bit 5, then a real press
    raw_a = 8'h00;
    run_a(8, strobes, lcode, lmulti);
    chk("t2_release_strobes", strobes, 32'd0);
    chk("t2_release_held", {24'd0, held_a}, 32'h00);
    raw_a = 8'h20;
    run_a(3, strobes, lcode, lmulti);
    raw_a = 8'h00;
    begin
      int s2;
      run_a(8, s2, lcode, lmulti);
      strobes += s2;
    end
    chk("t2_glitch_strobes", strobes, 32'd0);
    chk("t2_glitch_held", {24'd0, held_a}, 32'h00);
    raw_a = 8'h20;
    run_a(10, strobes, lcode, lmulti);
    chk("t2_press_strobes", strobes, 32'd1);
    chk("t2_press_code", {29'd0, lcode}, 32'd5);
    chk("t2_press_multi", {31'd0, lmulti}, 32'd0);

    // 3: simultaneous press of buttons 1 and 7
    raw_a = 8'h00;
    run_a(8, strobes, lcode, lmulti);
    raw_a = 8'h82;
    run_a(10, strobes, lcode, lmulti);
    chk("t3_strobes", strobes, 32'd1);
    chk("t3_code", {29'd0, lcode}, 32'd1);
    chk("t3_multi", {31'd0, lmulti}, 32'd1);
    chk("t3_held", {24'd0, held_a}, 32'h82);

    // 4: press lost while disabled, no replay on enable, fresh press reported
    raw_a = 8'h00;
    run_a(8, strobes, lcode, lmulti);
    en_a  = 1'b0;
    raw_a = 8'h08;
    run_a(8, strobes, lcode, lmulti);
    chk("t4_disabled_strobes", strobes, 32'd0);
    chk("t4_disabled_held", {24'd0, held_a}, 32'h08);
    en_a = 1'b1;
    run_a(5, strobes, lcode, lmulti);
    chk("t4_no_replay", strobes, 32'd0);
    raw_a = 8'h00;
    run_a(6, strobes, lcode, lmulti);
    chk("t4_release_held", {24'd0, held_a}, 32'h00);
    raw_a = 8'h08;
    run_a(10, strobes, lcode, lmulti);
    chk("t4_press_strobes", strobes, 32'd1);
    chk("t4_press_code", {29'd0, lcode}, 32'd3);

    // 5: reset pulse mid-debounce of button 0
    raw_a = 8'h00;
    run_a(8, strobes, lcode, lmulti);
    raw_a = 8'h01;
    run_a(4, strobes, lcode, lmulti);
    chk("t5_pre_reset_strobes", strobes, 32'd0);
    rst_a = 1'b1;
    tick();
    chk("t5_rst_valid", {31'd0, val_a}, 32'd0);
    chk("t5_rst_code",  {29'd0, code_a}, 32'd0);
    chk("t5_rst_held",  {24'd0, held_a}, 32'd0);
    rst_a = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("t5_pre_valid", {31'd0, val_a}, 32'd0);
    end
    tick();
    chk("t5_valid", {31'd0, val_a}, 32'd1);
    chk("t5_code",  {29'd0, code_a}, 32'd0);
    chk("t5_held",  {24'd0, held_a}, 32'h01);
    tick();
    chk("t5_one_cycle", {31'd0, val_a}, 32'd0);

    // 6: single-sample debounce, staggered presses on buttons 6 and 7
    rst_b = 1'b0;
    tick();
    chk("t6_idle_valid", {31'd0, val_b}, 32'd0);
    raw_b = 8'h40;
    tick();
    raw_b = 8'hC0;
    chk("t6_n1_valid", {31'd0, val_b}, 32'd0);
    tick();
    chk("t6_n2_valid", {31'd0, val_b}, 32'd0);
    tick();
    chk("t6_first_valid", {31'd0, val_b}, 32'd1);
    chk("t6_first_code",  {29'd0, code_b}, 32'd6);
    chk("t6_first_multi", {31'd0, mul_b}, 32'd0);
    tick();
    chk("t6_second_valid", {31'd0, val_b}, 32'd1);
    chk("t6_second_code",  {29'd0, code_b}, 32'd7);
    chk("t6_second_multi", {31'd0, mul_b}, 32'd0);
    tick();
    chk("t6_end_valid", {31'd0, val_b}, 32'd0);
    chk("t6_held", {24'd0, held_b}, 32'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
